rah_decoder_mc: RTL and testbench
=================================

# rah_decoder_mc

Parametrised multi-channel packet demultiplexer for the RAH receive path. It parses a framed word stream arriving from the MIPI receiver and steers each packet's payload into one of `TOTAL_APPS` per-application synchronous FIFOs. Applications drain their FIFOs with a request/valid handshake. Compared with the fixed decoder, it adds:

- parametrised width, depth and channel count;
- explicit length framing;
- invalid-ID discard;
- clearable per-channel overflow errors;
- a single-clock, asynchronous-reset build for designs with no per-app read clocks.

## Interface

Parameters:

- `DATA_WIDTH`, default 48: stream and FIFO word width; must be ≥ 8 + `LEN_WIDTH`.
- `TOTAL_APPS`, default 4: number of application channels, 1..255.
- `FIFO_DEPTH`, default 16: words per channel FIFO; power of two, ≥ 4.
- `LEN_WIDTH`, default 16: width of the header length field.
- `ALMOST_EMPTY_THRESH`, default 2: `data_queue_almost_empty[i]` is high when the word count is ≤ this value.

Ports (name, direction, width, meaning):

- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mipi_data` in `DATA_WIDTH`: input stream word.
- `mipi_rx_valid` in 1: `mipi_data` is valid this cycle. No backpressure.
- `request_data` in `TOTAL_APPS`: per-channel pop request.
- `error_clear` in `TOTAL_APPS`: per-channel clear for `error`.
- `rd_data` out `TOTAL_APPS*DATA_WIDTH`: channel i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rd_valid` out `TOTAL_APPS`: `rd_data` slice i is valid this cycle.
- `data_queue_empty` out `TOTAL_APPS`: channel FIFO count == 0.
- `data_queue_almost_empty` out `TOTAL_APPS`: count ≤ `ALMOST_EMPTY_THRESH`.
- `end_of_packet` out 1: one-cycle pulse when a packet completes.
- `error` out `TOTAL_APPS`: sticky overflow flag per channel.
- `bad_header` out 1: one-cycle pulse when a header carries an invalid app ID.

## Operation

Header word layout:

- Bits [7:0]: app ID.
- Bits [8+LEN_WIDTH-1:8]: payload length L, in words.
- Remaining bits are ignored.

Parser FSM (states IDLE, PAYLOAD, DISCARD). The FSM advances only on cycles where `mipi_rx_valid` = 1.

- **IDLE**
  - Each valid word is a header.
  - ID < `TOTAL_APPS` and L > 0: latch ID, set `remaining` = L, go to PAYLOAD.
  - ID < `TOTAL_APPS` and L = 0: pulse `end_of_packet`, stay in IDLE.
  - ID ≥ `TOTAL_APPS`: pulse `bad_header`. Go to DISCARD with `remaining` = L; if L = 0, stay in IDLE.
- **PAYLOAD**
  - Each valid word is written to the latched channel and decrements `remaining`.
  - On the word that takes `remaining` from 1 to 0: pulse `end_of_packet`, go to IDLE.
- **DISCARD**
  - Each valid word is dropped and decrements `remaining`.
  - On the last word: go to IDLE. No `end_of_packet` pulse.

FIFO rules:

- A write is accepted when count < `FIFO_DEPTH`, or when the same channel pops in the same cycle.
- Otherwise the word is dropped and `error[i]` is set. Packet counting continues, so framing is preserved.
- A pop takes effect when `request_data[i]` = 1 and count > 0.
- A request on an empty FIFO is ignored: no error, and `rd_valid[i]` stays 0.
- Simultaneous push and pop on the same channel leaves the count unchanged.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap modulo the depth. The count is `log2(FIFO_DEPTH)+1` bits.

Error flag rules:

- `error[i]` stays set until `error_clear[i]` is asserted.
- If a set and a clear occur in the same cycle, the set wins.

## Timing

Reset values (on `rst` = 1):

- FSM to IDLE; `remaining` = 0; all pointers and counts = 0.
- `rd_data` = 0, `rd_valid` = 0.
- `data_queue_empty` = all ones, `data_queue_almost_empty` = all ones.
- `error` = 0, `end_of_packet` = 0, `bad_header` = 0.
- Reset mid-packet discards the partial packet and all FIFO contents. The first valid word after reset is treated as a header.

Latencies:

- A payload word accepted at edge N is counted at edge N.
- `data_queue_empty` and `data_queue_almost_empty` are registered from the count and update after edge N.
- A pop requested in cycle N presents `rd_data` with `rd_valid` = 1 in cycle N+1.
- Back-to-back requests sustain one word per cycle.
- `end_of_packet` and `bad_header` are registered: they assert in the cycle after the triggering word's edge, for exactly one cycle.
- Headers may follow the final payload word with zero gap.

## Test plan

- **Single packet:** reset; send header ID=1, L=3, then words A, B, C.
  - `end_of_packet` pulses once, one cycle after C.
  - `data_queue_empty[1]` falls after A.
  - Three pops return A, B, C with `rd_valid` one cycle after each request.
- **Overflow:** send header ID=0 with L=`FIFO_DEPTH`+2 and no pops.
  - Count saturates at 16; the last 2 words are dropped.
  - `error[0]` is set and stays set until an `error_clear[0]` pulse, after which it is 0.
  - The next header is still parsed correctly.
- **Invalid ID:** send header ID=7 (`TOTAL_APPS`=4), L=2, two words, then header ID=2, L=1, word X.
  - `bad_header` pulses once; no FIFO changes during the discarded packet.
  - Channel 2 then holds X and `end_of_packet` pulses once.
- **Push/pop on full:** fill channel 3 to full, then push and pop in the same cycle.
  - The write is accepted, the count stays 16, no error is set, and the popped word is the oldest.
- **Zero length and gaps:** send header ID=0, L=0, then header ID=0, L=2 with `mipi_rx_valid` gaps between the payload words.
  - Two `end_of_packet` pulses; channel 0 holds exactly 2 words.
  - `data_queue_almost_empty[0]` stays 1 throughout.
- **Reset mid-packet:** assert `rst` after 1 of 3 payload words, then release.
  - All FIFOs are empty and all flags return to their reset values.
  - The next valid word is parsed as a header.

Source files
------------

// File: rtl/rah_decoder_mc.sv
// rah_decoder_mc: framed-stream demultiplexer feeding TOTAL_APPS synchronous
// FIFOs, with length framing, invalid-ID discard and sticky overflow flags.
module rah_decoder_mc #(
  parameter int unsigned DATA_WIDTH          = 48,
  parameter int unsigned TOTAL_APPS          = 4,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned LEN_WIDTH           = 16,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            mipi_data,
  input  logic                             mipi_rx_valid,
  input  logic [TOTAL_APPS-1:0]            request_data,
  input  logic [TOTAL_APPS-1:0]            error_clear,
  output logic [TOTAL_APPS*DATA_WIDTH-1:0] rd_data,
  output logic [TOTAL_APPS-1:0]            rd_valid,
  output logic [TOTAL_APPS-1:0]            data_queue_empty,
  output logic [TOTAL_APPS-1:0]            data_queue_almost_empty,
  output logic                             end_of_packet,
  output logic [TOTAL_APPS-1:0]            error,
  output logic                             bad_header
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CH_W  = (TOTAL_APPS > 1) ? $clog2(TOTAL_APPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic                 eop_q, eop_d;
  logic                 bad_q, bad_d;
  logic                 push_req_c;

  logic [7:0]           hdr_id_c;
  logic [LEN_WIDTH-1:0] hdr_len_c;
  logic                 hdr_ok_c;

  // Header field extraction; only meaningful while the parser is in IDLE.
  assign hdr_id_c  = mipi_data[7:0];
  assign hdr_len_c = mipi_data[8 +: LEN_WIDTH];
  assign hdr_ok_c  = (32'(hdr_id_c) < TOTAL_APPS);

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      ch_q        <= '0;
      eop_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ch_q        <= ch_d;
      eop_q       <= eop_d;
      bad_q       <= bad_d;
    end
  end

  // Parser next-state: header decode, payload steering and discard counting.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ch_d        = ch_q;
    eop_d       = 1'b0;
    bad_d       = 1'b0;
    push_req_c  = 1'b0;
    if (mipi_rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_ok_c) begin
            if (hdr_len_c != '0) begin
              ch_d        = CH_W'(hdr_id_c);
              remaining_d = hdr_len_c;
              state_d     = ST_PAYLOAD;
            end else begin
              eop_d = 1'b1;
            end
          end else begin
            bad_d = 1'b1;
            if (hdr_len_c != '0) begin
              remaining_d = hdr_len_c;
              state_d     = ST_DISCARD;
            end
          end
        end
        ST_PAYLOAD: begin
          push_req_c  = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end
      endcase
    end
  end

  assign end_of_packet = eop_q;
  assign bad_header    = bad_q;

  for (genvar i = 0; i < TOTAL_APPS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push_c, pop_c, wr_c, ovf_c;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvld_q, empty_q, aempty_q, err_q;

    // Push/pop qualification; a full FIFO still accepts when it pops too.
    always_comb begin
      push_c   = push_req_c && (ch_q == CH_W'(i));
      pop_c    = request_data[i] && (cnt_q != '0);
      wr_c     = push_c && ((cnt_q < CNT_W'(FIFO_DEPTH)) || pop_c);
      ovf_c    = push_c && !wr_c;
      wr_ptr_d = wr_c  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_c && !pop_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!wr_c && pop_c) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= mipi_data;
      end
    end

    // Pointers, count, read port and status flags.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        rdata_q  <= '0;
        rvld_q   <= 1'b0;
        empty_q  <= 1'b1;
        aempty_q <= 1'b1;
        err_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        rvld_q   <= pop_c;
        if (pop_c) begin
          rdata_q <= mem_q[rd_ptr_q];
        end
        empty_q  <= (cnt_d == '0);
        aempty_q <= (32'(cnt_d) <= ALMOST_EMPTY_THRESH);
        err_q    <= ovf_c | (err_q & ~error_clear[i]);
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    assign rd_valid[i]                         = rvld_q;
    assign data_queue_empty[i]                 = empty_q;
    assign data_queue_almost_empty[i]          = aempty_q;
    assign error[i]                            = err_q;
  end

endmodule

// File: tb/tb_rah_decoder_mc.sv
// tb_rah_decoder_mc: randomized packet stream checked against a queue-based
// reference model that knows each word's role from the packet generator.
module tb_rah_decoder_mc;

  localparam int unsigned DW    = 48;
  localparam int unsigned NA    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 16;
  localparam int unsigned AET   = 2;
  localparam int          NCYC  = 4500;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    mipi_data;
  logic             mipi_rx_valid;
  logic [NA-1:0]    request_data;
  logic [NA-1:0]    error_clear;
  logic [NA*DW-1:0] rd_data;
  logic [NA-1:0]    rd_valid;
  logic [NA-1:0]    data_queue_empty;
  logic [NA-1:0]    data_queue_almost_empty;
  logic             end_of_packet;
  logic [NA-1:0]    error;
  logic             bad_header;

  rah_decoder_mc #(
    .DATA_WIDTH         (DW),
    .TOTAL_APPS         (NA),
    .FIFO_DEPTH         (DEPTH),
    .LEN_WIDTH          (LW),
    .ALMOST_EMPTY_THRESH(AET)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mipi_data              (mipi_data),
    .mipi_rx_valid          (mipi_rx_valid),
    .request_data           (request_data),
    .error_clear            (error_clear),
    .rd_data                (rd_data),
    .rd_valid               (rd_valid),
    .data_queue_empty       (data_queue_empty),
    .data_queue_almost_empty(data_queue_almost_empty),
    .end_of_packet          (end_of_packet),
    .error                  (error),
    .bad_header             (bad_header)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    bit            hdr;
    bit            pay;
    int            ch;
    bit            eop;
    bit            bad;
  } item_t;

  item_t         stream[$];
  logic [DW-1:0] mq[NA][$];
  bit            exp_err[NA];
  bit            exp_rdv[NA];
  logic [DW-1:0] exp_rdd[NA];
  bit            exp_eop;
  bit            exp_bad;
  int            checks;
  int            errors;
  int            resets;

  // Count a comparison and report it when observed differs from expected.
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Append one packet (header plus payload) with each word's expected effect.
  task automatic gen_packet();
    int            id;
    int            len;
    item_t         it;
    logic [DW-1:0] w;
    id = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NA, 255))
                                     : int'($urandom_range(0, NA - 1));
    case ($urandom_range(0, 9))
      0:       len = 0;
      1:       len = int'($urandom_range(DEPTH, DEPTH + 6));
      default: len = int'($urandom_range(1, 6));
    endcase
    w          = rnd_word();
    w[7:0]     = 8'(id);
    w[8 +: LW] = LW'(len);
    it.word = w;
    it.hdr  = 1'b1;
    it.pay  = 1'b0;
    it.ch   = id;
    it.eop  = (id < int'(NA)) && (len == 0);
    it.bad  = (id >= int'(NA));
    stream.push_back(it);
    for (int k = 0; k < len; k++) begin
      it.word = rnd_word();
      it.hdr  = 1'b0;
      it.pay  = (id < int'(NA));
      it.ch   = id;
      it.eop  = (id < int'(NA)) && (k == len - 1);
      it.bad  = 1'b0;
      stream.push_back(it);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NA); i++) begin
      mq[i].delete();
      exp_err[i] = 1'b0;
      exp_rdv[i] = 1'b0;
      exp_rdd[i] = '0;
    end
    exp_eop = 1'b0;
    exp_bad = 1'b0;
  endtask

  task automatic check_reset();
    for (int i = 0; i < int'(NA); i++) begin
      chk($sformatf("rst_rdd%0d", i), 64'(rd_data[i*DW +: DW]), 64'(0));
    end
    chk("rst_rdv",    64'(rd_valid), 64'(0));
    chk("rst_empty",  64'(data_queue_empty), 64'({NA{1'b1}}));
    chk("rst_aempty", 64'(data_queue_almost_empty), 64'({NA{1'b1}}));
    chk("rst_err",    64'(error), 64'(0));
    chk("rst_eop",    64'(end_of_packet), 64'(0));
    chk("rst_bad",    64'(bad_header), 64'(0));
  endtask

  task automatic check_outputs();
    for (int i = 0; i < int'(NA); i++) begin
      chk($sformatf("rdv%0d", i), 64'(rd_valid[i]), 64'(exp_rdv[i]));
      if (exp_rdv[i]) begin
        chk($sformatf("rdd%0d", i), 64'(rd_data[i*DW +: DW]), 64'(exp_rdd[i]));
      end
      chk($sformatf("empty%0d", i), 64'(data_queue_empty[i]), 64'(mq[i].size() == 0));
      chk($sformatf("aempty%0d", i), 64'(data_queue_almost_empty[i]),
          64'(mq[i].size() <= int'(AET)));
      chk($sformatf("err%0d", i), 64'(error[i]), 64'(exp_err[i]));
    end
    chk("eop", 64'(end_of_packet), 64'(exp_eop));
    chk("bad", 64'(bad_header), 64'(exp_bad));
  endtask

  // Drive one cycle of random stimulus and predict its effect at the next edge.
  task automatic drive_and_model(input int cyc);
    int            ph;
    int            vp;
    int            rp;
    bit            v;
    logic [NA-1:0] rq;
    logic [NA-1:0] cl;
    item_t         it;
    bit            ovf[NA];
    ph = (cyc / 250) % 3;
    vp = (ph == 1) ? 50 : 85;
    rp = (ph == 0) ? 5 : ((ph == 1) ? 75 : 35);
    v  = (int'($urandom_range(0, 99)) < vp);
    for (int i = 0; i < int'(NA); i++) begin
      rq[i] = (int'($urandom_range(0, 99)) < rp);
      cl[i] = ($urandom_range(0, 99) < 3);
    end
    mipi_rx_valid = v;
    request_data  = rq;
    error_clear   = cl;
    mipi_data     = rnd_word();
    for (int i = 0; i < int'(NA); i++) begin
      ovf[i]     = 1'b0;
      exp_rdv[i] = rq[i] && (mq[i].size() > 0);
      if (exp_rdv[i]) exp_rdd[i] = mq[i].pop_front();
    end
    exp_eop = 1'b0;
    exp_bad = 1'b0;
    if (v) begin
      if (stream.size() == 0) gen_packet();
      it        = stream.pop_front();
      mipi_data = it.word;
      if (it.pay) begin
        if (mq[it.ch].size() < int'(DEPTH)) mq[it.ch].push_back(it.word);
        else ovf[it.ch] = 1'b1;
      end
      exp_eop = it.eop;
      exp_bad = it.bad;
    end
    for (int i = 0; i < int'(NA); i++) begin
      exp_err[i] = ovf[i] | (exp_err[i] & ~cl[i]);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    resets        = 0;
    rst           = 1'b1;
    mipi_rx_valid = 1'b0;
    mipi_data     = '0;
    request_data  = '0;
    error_clear   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Reset only while the next pending word is payload, i.e. mid-packet.
      if (resets < 3 && cyc >= 1000 * (resets + 1) && stream.size() > 0 && !stream[0].hdr) begin
        rst           = 1'b1;
        mipi_rx_valid = 1'b0;
        request_data  = '0;
        error_clear   = '0;
        #1;
        check_reset();
        model_reset();
        stream.delete();
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        resets++;
      end
      drive_and_model(cyc);
      @(negedge clk);
      check_outputs();
    end
    chk("resets_done", 64'(resets), 64'(3));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
